// File: rtl/ctrl_pkg.sv
// Shared types and constants for the pipeline control path.
package ctrl_pkg;

    // Per-instruction control bundle carried down the pipeline.
    typedef struct packed {
        logic reg_write;
        logic mem_to_reg;
        logic mem_write;
        logic branch_eq;
        logic alu_src;
    } ctrl_t;

    localparam ctrl_t BUBBLE = '0;

    // Operand forward selects.
    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_WB  = 2'b01,
        FWD_MEM = 2'b10
    } fwd_e;

    // Opcodes as produced by the main decoder.
    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_J    = 6'b000010;

    // An instruction reads rt unless it takes an immediate as operand B,
    // except stores and branches, which read rt regardless.
    function automatic logic uses_rt(input logic alu_src, input logic mem_write,
                                     input logic branch_eq);
        return ~alu_src | mem_write | branch_eq;
    endfunction

endpackage

// File: rtl/ctrl_pipe_hazard_fwd.sv
// Combinational hazard unit: load-use stall, branch/jump flush and
// EX-operand forwarding selects.
module hazard_fwd
    import ctrl_pkg::*;
#(
    parameter int unsigned REG_AW = 5
) (
    input  logic              i_id_alu_src,
    input  logic              i_id_mem_write,
    input  logic              i_id_branch_eq,
    input  logic              i_id_jump,
    input  logic [REG_AW-1:0] i_id_rs,
    input  logic [REG_AW-1:0] i_id_rt,
    input  logic              i_ex_reg_write,
    input  logic              i_ex_mem_to_reg,
    input  logic              i_ex_branch_eq,
    input  logic              i_ex_zero,
    input  logic [REG_AW-1:0] i_ex_rs,
    input  logic [REG_AW-1:0] i_ex_rt,
    input  logic [REG_AW-1:0] i_ex_dst,
    input  logic              i_mem_reg_write,
    input  logic              i_mem_mem_to_reg,
    input  logic [REG_AW-1:0] i_mem_dst,
    input  logic              i_wb_reg_write,
    input  logic [REG_AW-1:0] i_wb_dst,
    output logic              o_stall,
    output logic              o_flush_ifid,
    output logic              o_branch_taken,
    output logic              o_jump_taken,
    output logic [1:0]        o_fwd_a,
    output logic [1:0]        o_fwd_b
);

    // MEM-stage ALU results win over WB; loads in MEM have no data yet.
    function automatic fwd_e fwd_pick(
        input logic [REG_AW-1:0] src,
        input logic              mem_rw,
        input logic              mem_m2r,
        input logic [REG_AW-1:0] mem_dst,
        input logic              wb_rw,
        input logic [REG_AW-1:0] wb_dst
    );
        if (mem_rw && !mem_m2r && (mem_dst != '0) && (mem_dst == src))
            return FWD_MEM;
        else if (wb_rw && (wb_dst != '0) && (wb_dst == src))
            return FWD_WB;
        else
            return FWD_RF;
    endfunction

    logic w_uses_rt;
    logic w_load_use;

    // Stall/flush priority: taken branch, then load-use stall, then jump.
    always_comb begin
        w_uses_rt      = uses_rt(i_id_alu_src, i_id_mem_write, i_id_branch_eq);
        w_load_use     = i_ex_mem_to_reg && i_ex_reg_write && (i_ex_dst != '0) &&
                         ((i_ex_dst == i_id_rs) || (w_uses_rt && (i_ex_dst == i_id_rt)));
        o_branch_taken = i_ex_branch_eq & i_ex_zero;
        o_stall        = w_load_use & ~o_branch_taken;
        o_jump_taken   = i_id_jump & ~o_branch_taken & ~o_stall;
        o_flush_ifid   = o_branch_taken | o_jump_taken;
    end

    // Forward selects for the two EX source operands.
    always_comb begin
        o_fwd_a = fwd_pick(i_ex_rs, i_mem_reg_write, i_mem_mem_to_reg, i_mem_dst,
                           i_wb_reg_write, i_wb_dst);
        o_fwd_b = fwd_pick(i_ex_rt, i_mem_reg_write, i_mem_mem_to_reg, i_mem_dst,
                           i_wb_reg_write, i_wb_dst);
    end

endmodule

// File: rtl/ctrl_pipe.sv
// Control pipeline: carries the decoded ID bundle through ID/EX, EX/MEM and
// MEM/WB and drives each stage's controls plus hazard handling.
module ctrl_pipe
    import ctrl_pkg::*;
#(
    parameter int unsigned REG_AW = 5,
    parameter int unsigned ALUC_W = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_reg_write,
    input  logic              id_mem_to_reg,
    input  logic              id_mem_write,
    input  logic              id_branch_eq,
    input  logic              id_jump,
    input  logic [ALUC_W-1:0] id_alu_c,
    input  logic              id_alu_src,
    input  logic              id_reg_dst,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              ex_zero,
    output logic              stall,
    output logic              flush_ifid,
    output logic              branch_taken,
    output logic              jump_taken,
    output logic [ALUC_W-1:0] ex_alu_c,
    output logic              ex_alu_src,
    output logic [1:0]        fwd_a,
    output logic [1:0]        fwd_b,
    output logic              mem_mem_write,
    output logic              wb_reg_write,
    output logic              wb_mem_to_reg,
    output logic [REG_AW-1:0] wb_dst
);

    ctrl_t             w_id_ctrl;
    logic [REG_AW-1:0] w_id_dst;
    logic              w_ex_bubble;

    ctrl_t             r_ex_ctrl;
    logic [ALUC_W-1:0] r_ex_alu_c;
    logic [REG_AW-1:0] r_ex_rs;
    logic [REG_AW-1:0] r_ex_rt;
    logic [REG_AW-1:0] r_ex_dst;

    logic              r_mem_reg_write;
    logic              r_mem_mem_to_reg;
    logic              r_mem_mem_write;
    logic [REG_AW-1:0] r_mem_dst;

    logic              r_wb_reg_write;
    logic              r_wb_mem_to_reg;
    logic [REG_AW-1:0] r_wb_dst;

    // Pack the decoder outputs and pick the destination register in ID.
    always_comb begin
        w_id_ctrl            = BUBBLE;
        w_id_ctrl.reg_write  = id_reg_write;
        w_id_ctrl.mem_to_reg = id_mem_to_reg;
        w_id_ctrl.mem_write  = id_mem_write;
        w_id_ctrl.branch_eq  = id_branch_eq;
        w_id_ctrl.alu_src    = id_alu_src;
        w_id_dst             = id_reg_dst ? id_rd : id_rt;
        w_ex_bubble          = branch_taken | stall;
    end

    hazard_fwd #(
        .REG_AW (REG_AW)
    ) u_hazard_fwd (
        .i_id_alu_src     (id_alu_src),
        .i_id_mem_write   (id_mem_write),
        .i_id_branch_eq   (id_branch_eq),
        .i_id_jump        (id_jump),
        .i_id_rs          (id_rs),
        .i_id_rt          (id_rt),
        .i_ex_reg_write   (r_ex_ctrl.reg_write),
        .i_ex_mem_to_reg  (r_ex_ctrl.mem_to_reg),
        .i_ex_branch_eq   (r_ex_ctrl.branch_eq),
        .i_ex_zero        (ex_zero),
        .i_ex_rs          (r_ex_rs),
        .i_ex_rt          (r_ex_rt),
        .i_ex_dst         (r_ex_dst),
        .i_mem_reg_write  (r_mem_reg_write),
        .i_mem_mem_to_reg (r_mem_mem_to_reg),
        .i_mem_dst        (r_mem_dst),
        .i_wb_reg_write   (r_wb_reg_write),
        .i_wb_dst         (r_wb_dst),
        .o_stall          (stall),
        .o_flush_ifid     (flush_ifid),
        .o_branch_taken   (branch_taken),
        .o_jump_taken     (jump_taken),
        .o_fwd_a          (fwd_a),
        .o_fwd_b          (fwd_b)
    );

    // ID/EX register: loads a fully zeroed bubble on reset, taken branch or stall.
    always_ff @(posedge clk) begin
        if (rst || w_ex_bubble) begin
            r_ex_ctrl  <= BUBBLE;
            r_ex_alu_c <= '0;
            r_ex_rs    <= '0;
            r_ex_rt    <= '0;
            r_ex_dst   <= '0;
        end else begin
            r_ex_ctrl  <= w_id_ctrl;
            r_ex_alu_c <= id_alu_c;
            r_ex_rs    <= id_rs;
            r_ex_rt    <= id_rt;
            r_ex_dst   <= w_id_dst;
        end
    end

    // EX/MEM and MEM/WB registers: advance every cycle, cleared on reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_mem_reg_write  <= 1'b0;
            r_mem_mem_to_reg <= 1'b0;
            r_mem_mem_write  <= 1'b0;
            r_mem_dst        <= '0;
            r_wb_reg_write   <= 1'b0;
            r_wb_mem_to_reg  <= 1'b0;
            r_wb_dst         <= '0;
        end else begin
            r_mem_reg_write  <= r_ex_ctrl.reg_write;
            r_mem_mem_to_reg <= r_ex_ctrl.mem_to_reg;
            r_mem_mem_write  <= r_ex_ctrl.mem_write;
            r_mem_dst        <= r_ex_dst;
            r_wb_reg_write   <= r_mem_reg_write;
            r_wb_mem_to_reg  <= r_mem_mem_to_reg;
            r_wb_dst         <= r_mem_dst;
        end
    end

    // Stage control outputs straight from the pipeline registers.
    always_comb begin
        ex_alu_c      = r_ex_alu_c;
        ex_alu_src    = r_ex_ctrl.alu_src;
        mem_mem_write = r_mem_mem_write;
        wb_reg_write  = r_wb_reg_write;
        wb_mem_to_reg = r_wb_mem_to_reg;
        wb_dst        = r_wb_dst;
    end

endmodule

// File: tb/tb_ctrl_pipe.sv
// Scoreboard bench for ctrl_pipe: stimulus queues per-cycle expectations,
// a negedge monitor compares them against the DUT outputs.
module tb_ctrl_pipe;

    logic       clk = 1'b0;
    logic       rst;
    logic       id_reg_write, id_mem_to_reg, id_mem_write, id_branch_eq, id_jump;
    logic [2:0] id_alu_c;
    logic       id_alu_src, id_reg_dst;
    logic [4:0] id_rs, id_rt, id_rd;
    logic       ex_zero;
    logic       stall, flush_ifid, branch_taken, jump_taken;
    logic [2:0] ex_alu_c;
    logic       ex_alu_src;
    logic [1:0] fwd_a, fwd_b;
    logic       mem_mem_write, wb_reg_write, wb_mem_to_reg;
    logic [4:0] wb_dst;

    ctrl_pipe #(
        .REG_AW (5),
        .ALUC_W (3)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .id_reg_write  (id_reg_write),
        .id_mem_to_reg (id_mem_to_reg),
        .id_mem_write  (id_mem_write),
        .id_branch_eq  (id_branch_eq),
        .id_jump       (id_jump),
        .id_alu_c      (id_alu_c),
        .id_alu_src    (id_alu_src),
        .id_reg_dst    (id_reg_dst),
        .id_rs         (id_rs),
        .id_rt         (id_rt),
        .id_rd         (id_rd),
        .ex_zero       (ex_zero),
        .stall         (stall),
        .flush_ifid    (flush_ifid),
        .branch_taken  (branch_taken),
        .jump_taken    (jump_taken),
        .ex_alu_c      (ex_alu_c),
        .ex_alu_src    (ex_alu_src),
        .fwd_a         (fwd_a),
        .fwd_b         (fwd_b),
        .mem_mem_write (mem_mem_write),
        .wb_reg_write  (wb_reg_write),
        .wb_mem_to_reg (wb_mem_to_reg),
        .wb_dst        (wb_dst)
    );

    always #5 clk = ~clk;

    typedef enum int {
        F_STALL, F_FLUSH, F_BT, F_JT, F_EXALUC, F_EXALUSRC,
        F_FWDA, F_FWDB, F_MEMW, F_WBRW, F_WBM2R, F_WBDST
    } fld_e;

    typedef struct {
        int         cyc;
        fld_e       f;
        logic [7:0] v;
    } exp_t;

    exp_t sb[$];
    int   cyc      = 0;
    int   n_checks = 0;
    int   n_fail   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [7:0] act(input fld_e f);
        case (f)
            F_STALL:    return {7'd0, stall};
            F_FLUSH:    return {7'd0, flush_ifid};
            F_BT:       return {7'd0, branch_taken};
            F_JT:       return {7'd0, jump_taken};
            F_EXALUC:   return {5'd0, ex_alu_c};
            F_EXALUSRC: return {7'd0, ex_alu_src};
            F_FWDA:     return {6'd0, fwd_a};
            F_FWDB:     return {6'd0, fwd_b};
            F_MEMW:     return {7'd0, mem_mem_write};
            F_WBRW:     return {7'd0, wb_reg_write};
            F_WBM2R:    return {7'd0, wb_mem_to_reg};
            default:    return {3'd0, wb_dst};
        endcase
    endfunction

    function automatic string fname(input fld_e f);
        case (f)
            F_STALL:    return "stall";
            F_FLUSH:    return "flush_ifid";
            F_BT:       return "branch_taken";
            F_JT:       return "jump_taken";
            F_EXALUC:   return "ex_alu_c";
            F_EXALUSRC: return "ex_alu_src";
            F_FWDA:     return "fwd_a";
            F_FWDB:     return "fwd_b";
            F_MEMW:     return "mem_mem_write";
            F_WBRW:     return "wb_reg_write";
            F_WBM2R:    return "wb_mem_to_reg";
            default:    return "wb_dst";
        endcase
    endfunction

    // Monitor: every expectation due this cycle is compared and retired.
    always @(negedge clk) begin
        exp_t keep[$];
        logic [7:0] a;
        keep = {};
        foreach (sb[i]) begin
            if (sb[i].cyc == cyc) begin
                a = act(sb[i].f);
                n_checks++;
                if (a !== sb[i].v) begin
                    n_fail++;
                    $display("FAIL cyc%0d %s: got %0h expected %0h", cyc, fname(sb[i].f), a, sb[i].v);
                end
            end else if (sb[i].cyc < cyc) begin
                n_checks++;
                n_fail++;
                $display("FAIL cyc%0d %s: check missed, expected %0h", sb[i].cyc, fname(sb[i].f), sb[i].v);
            end else begin
                keep.push_back(sb[i]);
            end
        end
        sb = keep;
    end

    task automatic expect_at(input int off, input fld_e f, input logic [7:0] v);
        exp_t e;
        e.cyc = cyc + off;
        e.f   = f;
        e.v   = v;
        sb.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        ex_zero = 1'b0;
    endtask

    task automatic set_id(input logic rw, m2r, mw, beq, j, input logic [2:0] aluc,
                          input logic asrc, rdst, input logic [4:0] rs, rt, rd);
        id_reg_write  = rw;
        id_mem_to_reg = m2r;
        id_mem_write  = mw;
        id_branch_eq  = beq;
        id_jump       = j;
        id_alu_c      = aluc;
        id_alu_src    = asrc;
        id_reg_dst    = rdst;
        id_rs         = rs;
        id_rt         = rt;
        id_rd         = rd;
    endtask

    task automatic op_nop();                       set_id(0,0,0,0,0,3'b000,0,0,0,0,0);   endtask
    task automatic op_add(input logic [4:0] d, s, t); set_id(1,0,0,0,0,3'b010,0,1,s,t,d); endtask
    task automatic op_addi(input logic [4:0] t, s); set_id(1,0,0,0,0,3'b010,1,0,s,t,0);   endtask
    task automatic op_lw(input logic [4:0] t, s);   set_id(1,1,0,0,0,3'b010,1,0,s,t,0);   endtask
    task automatic op_sw(input logic [4:0] t, s);   set_id(0,0,1,0,0,3'b010,1,0,s,t,0);   endtask
    task automatic op_beq(input logic [4:0] s, t);  set_id(0,0,0,1,0,3'b110,0,0,s,t,0);   endtask
    task automatic op_j(input logic [4:0] s);       set_id(0,0,0,0,1,3'b000,0,0,s,0,0);   endtask

    task automatic op_rand();
        set_id(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'b0,
               3'($urandom), 1'($urandom), 1'($urandom),
               5'($urandom), 5'($urandom), 5'($urandom));
        ex_zero = 1'($urandom);
    endtask

    initial begin
        // Reset with random ID inputs.
        rst = 1'b1;
        op_rand();
        tick();
        op_rand();
        for (int unsigned k = 0; k < 12; k++) expect_at(0, fld_e'(k), 8'h00);
        tick();
        rst = 1'b0;

        // Back-to-back ALU forwarding; first add reaches WB 3 edges later.
        op_add(3, 1, 2);
        expect_at(0, F_EXALUC, 8'h0);
        expect_at(0, F_WBRW, 8'h0);
        expect_at(1, F_EXALUC, 8'h2);
        expect_at(2, F_WBRW, 8'h0);
        expect_at(3, F_WBRW, 8'h1);
        expect_at(3, F_WBDST, 8'h3);
        tick();
        op_add(4, 3, 3);
        expect_at(0, F_FWDA, 8'h0);
        expect_at(0, F_FWDB, 8'h0);
        tick();
        op_add(5, 3, 0);
        expect_at(0, F_FWDA, 8'h2);
        expect_at(0, F_FWDB, 8'h2);
        tick();
        op_nop();
        expect_at(0, F_FWDA, 8'h1);
        expect_at(0, F_FWDB, 8'h0);
        tick();
        op_nop();
        expect_at(0, F_FWDA, 8'h0);
        tick();

        // Load-use with add, then addi, then lw r0, then rt-only cases.
        op_lw(5, 1);
        tick();
        op_add(6, 5, 1);
        expect_at(0, F_STALL, 8'h1);
        expect_at(0, F_EXALUSRC, 8'h1);
        expect_at(0, F_FLUSH, 8'h0);
        tick();
        op_add(6, 5, 1);
        expect_at(0, F_STALL, 8'h0);
        expect_at(0, F_EXALUC, 8'h0);
        expect_at(0, F_EXALUSRC, 8'h0);
        tick();
        op_lw(5, 2);
        expect_at(0, F_FWDA, 8'h1);
        expect_at(0, F_FWDB, 8'h0);
        expect_at(0, F_WBM2R, 8'h1);
        expect_at(0, F_STALL, 8'h0);
        tick();
        op_addi(6, 5);
        expect_at(0, F_STALL, 8'h1);
        tick();
        op_addi(6, 5);
        expect_at(0, F_STALL, 8'h0);
        expect_at(0, F_EXALUC, 8'h0);
        tick();
        op_lw(0, 1);
        tick();
        op_add(6, 0, 0);
        expect_at(0, F_STALL, 8'h0);
        tick();
        op_lw(5, 1);
        tick();
        op_addi(5, 7);
        expect_at(0, F_STALL, 8'h0);
        tick();
        op_lw(5, 1);
        tick();
        op_sw(5, 7);
        expect_at(0, F_STALL, 8'h1);
        tick();
        op_sw(5, 7);
        expect_at(0, F_STALL, 8'h0);
        expect_at(1, F_MEMW, 8'h0);
        expect_at(2, F_MEMW, 8'h1);
        tick();
        op_nop();
        tick();

        // Branch taken, then not taken.
        op_beq(1, 2);
        tick();
        op_add(7, 1, 2);
        ex_zero = 1'b1;
        expect_at(0, F_BT, 8'h1);
        expect_at(0, F_FLUSH, 8'h1);
        expect_at(0, F_STALL, 8'h0);
        expect_at(0, F_JT, 8'h0);
        expect_at(0, F_EXALUC, 8'h6);
        tick();
        op_nop();
        expect_at(0, F_EXALUC, 8'h0);
        expect_at(0, F_BT, 8'h0);
        tick();
        op_beq(1, 2);
        tick();
        op_add(7, 1, 2);
        expect_at(0, F_BT, 8'h0);
        expect_at(0, F_FLUSH, 8'h0);
        tick();
        op_nop();
        expect_at(0, F_EXALUC, 8'h2);
        tick();

        // Jump alone, jump under taken branch, jump under load-use stall.
        op_j(0);
        expect_at(0, F_JT, 8'h1);
        expect_at(0, F_FLUSH, 8'h1);
        tick();
        op_nop();
        expect_at(0, F_JT, 8'h0);
        expect_at(0, F_FLUSH, 8'h0);
        expect_at(0, F_EXALUC, 8'h0);
        tick();
        op_beq(1, 2);
        tick();
        op_j(0);
        ex_zero = 1'b1;
        expect_at(0, F_BT, 8'h1);
        expect_at(0, F_JT, 8'h0);
        expect_at(0, F_FLUSH, 8'h1);
        tick();
        op_lw(5, 1);
        tick();
        op_j(5);
        expect_at(0, F_STALL, 8'h1);
        expect_at(0, F_JT, 8'h0);
        expect_at(0, F_FLUSH, 8'h0);
        tick();
        op_j(5);
        expect_at(0, F_STALL, 8'h0);
        expect_at(0, F_JT, 8'h1);
        tick();
        op_nop();
        tick();

        // Reset while lw is in EX and add is in MEM.
        op_add(3, 1, 2);
        tick();
        op_lw(5, 1);
        tick();
        op_add(6, 5, 3);
        rst = 1'b1;
        expect_at(0, F_STALL, 8'h1);
        tick();
        rst = 1'b0;
        op_add(6, 5, 3);
        expect_at(0, F_STALL, 8'h0);
        expect_at(0, F_EXALUC, 8'h0);
        expect_at(0, F_MEMW, 8'h0);
        expect_at(0, F_WBRW, 8'h0);
        expect_at(0, F_WBDST, 8'h0);
        expect_at(0, F_FWDA, 8'h0);
        tick();
        op_nop();
        expect_at(0, F_FWDA, 8'h0);
        expect_at(0, F_FWDB, 8'h0);
        expect_at(0, F_EXALUC, 8'h2);
        expect_at(0, F_WBRW, 8'h0);
        tick();

        for (int i = 0; i < 3; i++) tick();
        if (sb.size() != 0) begin
            n_checks += sb.size();
            n_fail   += sb.size();
            $display("FAIL leftover: %0d expectations never checked, required 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
